// File: rtl/para_frame_setter.sv
// para_frame_setter: parses UART parameter frames, strobes the addressed channel, replies ACK/NAK.
// Define PARA_CRC_CHECK_EN to verify the received checksum byte.
module para_frame_setter #(
  parameter int          NUM_CH      = 6,
  parameter int          PARA_BYTES  = 4,
  parameter logic [7:0]  CMD_BASE    = 8'h10,
  parameter logic [7:0]  START_CODE  = 8'hAA,
  parameter logic [7:0]  END_CODE    = 8'h55,
  parameter logic [7:0]  OK_CODE     = 8'hFF,
  parameter logic [7:0]  ERR_CODE    = 8'h00,
  parameter int          CS_HOLD     = 20,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ok,
  input  logic                    tx_idle,
  output logic [7:0]              tx_data,
  output logic                    start_tx,
  output logic [8*PARA_BYTES-1:0] para,
  output logic [NUM_CH-1:0]       para_cs,
  output logic                    set_para_done,
  output logic                    busy,
  output logic                    frame_err
);
  localparam int PW = 8*PARA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam int HW = $clog2(CS_HOLD+1);
`ifdef PARA_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, CMD, LEN_L, LEN_H, DATA, SUM, ENDB, APPLY, REPLY} state_t;
  state_t state_q, state_d;
  logic [1:0] rx_s_q, tx_s_q;
  logic [7:0] cmd_q, cmd_d, len_l_q, len_l_d, len_h_q, len_h_d, sum_q, sum_d, acc_q, acc_d;
  logic [7:0] status_q, status_d, tx_data_q, tx_data_d, ch, rb;
  logic [PW-1:0] shadow_q, shadow_d, para_q, para_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] phase_q, phase_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] cs_q, cs_d;
  logic start_tx_q, start_tx_d, done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic rx_rise, tx_done, good;
  assign rx_rise = rx_s_q[0] & ~rx_s_q[1];
  assign tx_done = tx_s_q[1] & ~tx_s_q[0];
  assign ch = cmd_q - CMD_BASE;
  assign good = (ch < 8'(NUM_CH)) && ({len_h_q, len_l_q} == 16'(PARA_BYTES)) &&
                (!CRC_EN || sum_q == ~acc_q) && (rx_data == END_CODE);
  assign rb = idx_q == 4'd0 ? START_CODE :
              idx_q == 4'd1 ? cmd_q :
              idx_q == 4'd2 ? 8'h01 :
              idx_q == 4'd3 ? 8'h00 :
              idx_q == 4'd4 ? status_q :
              idx_q == 4'd5 ? ~(cmd_q + 8'h01 + status_q) : END_CODE;
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_l_d    = len_l_q;
    len_h_d    = len_h_q;
    sum_d      = sum_q;
    acc_d      = acc_q;
    status_d   = status_q;
    tx_data_d  = tx_data_q;
    shadow_d   = shadow_q;
    para_d     = para_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    err_d      = err_q;
    start_tx_d = 1'b0;
    done_d     = 1'b0;
    tmo_d      = (rx_rise || state_q inside {IDLE, APPLY, REPLY}) ? '0 : tmo_q + TW'(1);
    case (state_q)
      IDLE: if (rx_rise && rx_data == START_CODE) begin
        acc_d   = '0;
        state_d = CMD;
      end
      CMD: if (rx_rise) begin
        cmd_d   = rx_data;
        acc_d   = acc_q + rx_data;
        state_d = LEN_L;
      end
      LEN_L: if (rx_rise) begin
        len_l_d = rx_data;
        acc_d   = acc_q + rx_data;
        state_d = LEN_H;
      end
      LEN_H: if (rx_rise) begin
        len_h_d = rx_data;
        acc_d   = acc_q + rx_data;
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (rx_rise) begin
        shadow_d = PW'({rx_data, shadow_q} >> 8);
        acc_d    = acc_q + rx_data;
        idx_d    = idx_q + 4'd1;
        state_d  = idx_q == 4'(PARA_BYTES-1) ? SUM : DATA;
      end
      SUM: if (rx_rise) begin
        sum_d   = rx_data;
        state_d = ENDB;
      end
      ENDB: if (rx_rise) begin
        status_d = good ? OK_CODE : ERR_CODE;
        err_d    = !good;
        para_d   = good ? shadow_q : para_q;
        hold_d   = '0;
        idx_d    = '0;
        phase_d  = '0;
        state_d  = good ? APPLY : REPLY;
      end
      APPLY: begin
        hold_d  = hold_q + HW'(1);
        state_d = hold_q == HW'(CS_HOLD-1) ? REPLY : APPLY;
      end
      REPLY: begin
        // load tx_data, pulse start_tx the cycle after, then wait for the byte to go out
        if (phase_q == 2'd0) begin
          tx_data_d = rb;
          phase_d   = 2'd1;
        end else if (phase_q == 2'd1) begin
          start_tx_d = 1'b1;
          phase_d    = 2'd2;
        end else if (tx_done) begin
          done_d  = idx_q == 4'd6;
          state_d = idx_q == 4'd6 ? IDLE : REPLY;
          idx_d   = idx_q + 4'd1;
          phase_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q inside {CMD, LEN_L, LEN_H, DATA, SUM, ENDB} && !rx_rise && tmo_q == TW'(TIMEOUT_CYC-1))
      state_d = IDLE;
    busy_d = state_d != IDLE;
    cs_d   = state_d == APPLY ? NUM_CH'(1) << ch : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_s_q     <= 2'b11;
      tx_s_q     <= 2'b11;
      cmd_q      <= '0;
      len_l_q    <= '0;
      len_h_q    <= '0;
      sum_q      <= '0;
      acc_q      <= '0;
      status_q   <= '0;
      tx_data_q  <= '0;
      shadow_q   <= '0;
      para_q     <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      cs_q       <= '0;
      start_tx_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s_q     <= {rx_s_q[0], rx_ok};
      tx_s_q     <= {tx_s_q[0], tx_idle};
      cmd_q      <= cmd_d;
      len_l_q    <= len_l_d;
      len_h_q    <= len_h_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      status_q   <= status_d;
      tx_data_q  <= tx_data_d;
      shadow_q   <= shadow_d;
      para_q     <= para_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      cs_q       <= cs_d;
      start_tx_q <= start_tx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end
  assign tx_data       = tx_data_q;
  assign start_tx      = start_tx_q;
  assign para          = para_q;
  assign para_cs       = cs_q;
  assign set_para_done = done_q;
  assign busy          = busy_q;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_para_frame_setter.sv
// tb_para_frame_setter: scoreboard bench; reply bytes are queued when a frame is sent and checked at start_tx.
module tb_para_frame_setter;
  localparam int TMO = 200;
  logic clk = 0, rst = 1, rx_ok = 0, tx_idle = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic start_tx, set_para_done, busy, frame_err;
  logic [31:0] para;
  logic [5:0] para_cs, cs_last = 0;
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, tx_cnt = 0, done_cnt = 0, cs_cycles = 0;
  logic exp_err;
  para_frame_setter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ok(rx_ok), .tx_idle(tx_idle),
    .tx_data(tx_data), .start_tx(start_tx), .para(para), .para_cs(para_cs),
    .set_para_done(set_para_done), .busy(busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (set_para_done) done_cnt++;
    if (para_cs != 0) begin
      cs_cycles++;
      cs_last = para_cs;
    end
  end
  // UART transmitter model: idle drops when a byte is launched, the fall is the "sent" event
  always @(negedge clk) if (start_tx) begin
    tx_cnt++;
    if (exp_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'h100);
    else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    tx_idle = 0;
    repeat (2) @(negedge clk);
    tx_idle = 1;
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ok = 1;
    repeat (3) @(negedge clk);
    rx_ok = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pl, input bit bad_sum);
    logic [7:0] s;
    s = cmd + 8'h04 + pl[7:0] + pl[15:8] + pl[23:16] + pl[31:24];
    s = ~s ^ {7'h0, bad_sum};
    send_byte(8'hAA); send_byte(cmd); send_byte(8'h04); send_byte(8'h00);
    send_byte(pl[7:0]); send_byte(pl[15:8]); send_byte(pl[23:16]); send_byte(pl[31:24]);
    send_byte(s); send_byte(8'h55);
  endtask
  task automatic push_reply(input logic [7:0] cmd, input bit ok);
    logic [7:0] st, cs;
    st = ok ? 8'hFF : 8'h00;
    cs = ~(cmd + 8'h01 + st);
    exp_q.push_back(8'hAA); exp_q.push_back(cmd); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(st); exp_q.push_back(cs); exp_q.push_back(8'h55);
  endtask
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] pl, input bit bad_sum, input bit ok);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    cs_cycles = 0;
    push_reply(cmd, ok);
    send_frame(cmd, pl, bad_sum);
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", done_cnt, d0 + 1);
    chk("q_empty", exp_q.size(), 0);
    chk("busy_after", {31'h0, busy}, 0);
  endtask
  initial begin
    int t0, n;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_start_tx", {31'h0, start_tx}, 0);
    chk("rst_para", para, 0);
    chk("rst_cs", {26'h0, para_cs}, 0);
    chk("rst_done", {31'h0, set_para_done}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_err", {31'h0, frame_err}, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    do_frame(8'h10, 32'h12345678, 0, 1);
    chk("t1_para", para, 32'h12345678);
    chk("t1_cs_len", cs_cycles, 20);
    chk("t1_cs_val", {26'h0, cs_last}, 32'h01);
    chk("t1_err", {31'h0, frame_err}, 0);
    do_frame(8'h16, 32'hAABBCCDD, 0, 0);
    chk("t2_para", para, 32'h12345678);
    chk("t2_cs_len", cs_cycles, 0);
    chk("t2_err", {31'h0, frame_err}, 1);
`ifdef PARA_CRC_CHECK_EN
    do_frame(8'h13, 32'hCAFEBABE, 1, 0);
    chk("t3_para", para, 32'h12345678);
    chk("t3_cs_len", cs_cycles, 0);
    exp_err = 1;
`else
    do_frame(8'h13, 32'hCAFEBABE, 1, 1);
    chk("t3_para", para, 32'hCAFEBABE);
    chk("t3_cs_len", cs_cycles, 20);
    chk("t3_cs_val", {26'h0, cs_last}, 32'h08);
    exp_err = 0;
`endif
    chk("t3_err", {31'h0, frame_err}, {31'h0, exp_err});
    t0 = tx_cnt;
    cs_cycles = 0;
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    repeat (TMO + 20) @(negedge clk);
    chk("t4_no_reply", tx_cnt, t0);
    chk("t4_busy", {31'h0, busy}, 0);
    chk("t4_err", {31'h0, frame_err}, {31'h0, exp_err});
    chk("t4_cs_len", cs_cycles, 0);
    do_frame(8'h11, 32'h0BADF00D, 0, 1);
    chk("t4_para", para, 32'h0BADF00D);
    chk("t4_cs_val", {26'h0, cs_last}, 32'h02);
    chk("t4_err2", {31'h0, frame_err}, 0);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
    t0 = tx_cnt;
    fork
      do_frame(8'h12, 32'h01020304, 0, 1);
      begin
        n = 0;
        while (tx_cnt == t0 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("t5_reply_start", {31'h0, tx_cnt != t0}, 1);
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h04);
      end
    join
    repeat (30) @(negedge clk);
    chk("t5_extra_dropped", {31'h0, busy}, 0);
    chk("t5_para", para, 32'h01020304);
    chk("t5_cs_val", {26'h0, cs_last}, 32'h04);
    t0 = tx_cnt;
    push_reply(8'h14, 1);
    send_frame(8'h14, 32'h55667788, 0);
    n = 0;
    while (tx_cnt < t0 + 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reply3_seen", tx_cnt, t0 + 3);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_start_tx", {31'h0, start_tx}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    chk("t6_para", para, 0);
    rst = 0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("t6_no_resume", tx_cnt, t0 + 3);
    do_frame(8'h15, 32'hDEADBEEF, 0, 1);
    chk("t6_para2", para, 32'hDEADBEEF);
    chk("t6_cs_val", {26'h0, cs_last}, 32'h20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
